// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: buffer occupancy states,
// status flag bit positions and the per-result flag bundle.
package alu_pkg;

    // Occupancy of the two-entry result buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Bit positions inside the 4-bit status register {N,Z,C,V}.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Flags of one result. The field order makes the packed value line up
    // with the status register layout {N,Z,C,V}.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flag_set_t;

endpackage

// File: rtl/alu_ovf_detect.sv
// Signed overflow detection for an add: overflow when both operands share
// a sign and the sum's sign differs from it.
module alu_ovf_detect (
    input  logic a_msb,
    input  logic b_msb,
    input  logic sum_msb,
    output logic v
);

    assign v = (a_msb == b_msb) && (sum_msb != a_msb);

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: registers adder results through a two-entry skid buffer
// (head + skid), computes overflow on acceptance and maintains the {N,Z,C,V}
// status register.
// Optional feature: define ALU_STICKY_OVF_EN to add a sticky overflow bit
// cleared by ovf_clr; otherwise ovf_sticky reads 0 and ovf_clr is ignored.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic             in_z,
    input  logic             in_n,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    input  logic             in_setf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v,
    output logic [3:0]       flags,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        flag_set_t        f;
    } entry_t;

    state_e    state_q, state_d;
    entry_t    head_q, skid_q, new_entry;
    logic      in_ready_q;
    logic      v_new;
    logic      accept, handoff;
    logic      head_load, head_from_skid, skid_load;
    flag_set_t flags_q;

    alu_ovf_detect u_ovf_detect (
        .a_msb   (in_a_msb),
        .b_msb   (in_b_msb),
        .sum_msb (in_sum[WIDTH-1]),
        .v       (v_new)
    );

    assign new_entry = '{sum: in_sum, f: '{n: in_n, z: in_z, c: in_cout, v: v_new}};

    assign accept  = in_valid && in_ready_q;
    assign handoff = out_valid && out_ready;

    // Next occupancy and which buffer registers load this cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_ONE;
                    head_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && handoff) begin
                    head_load = 1'b1;
                end else if (accept) begin
                    state_d   = ST_FULL;
                    skid_load = 1'b1;
                end else if (handoff) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (handoff) begin
                    state_d        = ST_ONE;
                    head_load      = 1'b1;
                    head_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Occupancy register plus a registered in_ready, so in_ready never
    // depends combinationally on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // Head and skid data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the buffer registers are reset because the head drives the
        // outputs directly and those must read zero while in reset.
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (head_load) head_q <= head_from_skid ? skid_q : new_entry;
            if (skid_load) skid_q <= new_entry;
        end
    end

    // Status register: loaded from the entry accepted this cycle when it
    // requests a flag update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (accept && in_setf) begin
            flags_q <= new_entry.f;
        end
    end

`ifdef ALU_STICKY_OVF_EN
    logic sticky_q;

    // Sticky overflow: a new overflow wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (accept && v_new) begin
            sticky_q <= 1'b1;
        end else if (ovf_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign ovf_sticky = sticky_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf_sticky     = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_sum   = head_q.sum;
    assign out_c     = head_q.f.c;
    assign out_z     = head_q.f.z;
    assign out_n     = head_q.f.n;
    assign out_v     = head_q.f.v;
    assign flags     = flags_q;

endmodule
